// File: rtl/forward_buffer.sv
// Commit-to-execute forwarding buffer: DEPTH-stage history of preg writes with
// zero-latency, newest-first bypass lookup. Optional hit counter under FORWARD_STATS_EN.
module forward_buffer #(
  parameter int WB_NUM = 2,
  parameter int RD_NUM = 4,
  parameter int DEPTH  = 2,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [WB_NUM-1:0]                  wb_valid,
  input  logic [WB_NUM*PREG_W-1:0]           wb_dst,
  input  logic [WB_NUM*DATA_W-1:0]           wb_data,
  input  logic [RD_NUM*PREG_W-1:0]           rd_addr,
  output logic [RD_NUM-1:0]                  rd_hit,
  output logic [RD_NUM*DATA_W-1:0]           rd_data,
  output logic [RD_NUM*$clog2(DEPTH+1)-1:0]  rd_age
`ifdef FORWARD_STATS_EN
  ,
  input  logic                               stats_clr,
  output logic [31:0]                        hit_count
`endif
);

  localparam int AGE_W = $clog2(DEPTH+1);

  // index 0 is stage 1 (newest registered), index DEPTH-1 is the oldest
  logic [WB_NUM-1:0]        stg_valid [DEPTH];
  logic [WB_NUM*PREG_W-1:0] stg_dst   [DEPTH];
  logic [WB_NUM*DATA_W-1:0] stg_data  [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) stg_valid[k] <= '0;
    end else begin
      stg_valid[0] <= wb_valid;
      for (int k = 1; k < DEPTH; k++) stg_valid[k] <= stg_valid[k-1];
    end
  end

  // payload only matters where valid is set, so it shifts without reset
  always_ff @(posedge clk) begin
    stg_dst[0]  <= wb_dst;
    stg_data[0] <= wb_data;
    for (int k = 1; k < DEPTH; k++) begin
      stg_dst[k]  <= stg_dst[k-1];
      stg_data[k] <= stg_data[k-1];
    end
  end

  always_comb begin
    logic [PREG_W-1:0] addr;
    logic              found;
    addr    = '0;
    found   = 1'b0;
    rd_hit  = '0;
    rd_data = '0;
    rd_age  = '0;
    for (int r = 0; r < RD_NUM; r++) begin
      addr  = rd_addr[r*PREG_W +: PREG_W];
      found = 1'b0;
      if (addr != '0) begin
        for (int i = 0; i < WB_NUM; i++) begin
          if (!found && !flush && wb_valid[i] && wb_dst[i*PREG_W +: PREG_W] == addr) begin
            found                      = 1'b1;
            rd_hit[r]                  = 1'b1;
            rd_data[r*DATA_W +: DATA_W] = wb_data[i*DATA_W +: DATA_W];
          end
        end
        for (int k = 0; k < DEPTH; k++) begin
          for (int i = 0; i < WB_NUM; i++) begin
            if (!found && stg_valid[k][i] && stg_dst[k][i*PREG_W +: PREG_W] == addr) begin
              found                       = 1'b1;
              rd_hit[r]                   = 1'b1;
              rd_data[r*DATA_W +: DATA_W] = stg_data[k][i*DATA_W +: DATA_W];
              rd_age[r*AGE_W +: AGE_W]    = AGE_W'(k + 1);
            end
          end
        end
      end
    end
  end

`ifdef FORWARD_STATS_EN
  localparam int POP_W = $clog2(RD_NUM+1);

  logic [POP_W-1:0] hit_pop;
  logic [32:0]      hit_sum;

  always_comb begin
    hit_pop = '0;
    for (int r = 0; r < RD_NUM; r++) hit_pop = hit_pop + POP_W'(rd_hit[r]);
    hit_sum = {1'b0, hit_count} + 33'(hit_pop);
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clr) hit_count <= '0;
    else if (hit_sum[32])   hit_count <= 32'hFFFF_FFFF;
    else                    hit_count <= hit_sum[31:0];
  end
`endif

endmodule
